sc_regbank: RTL and testbench
=============================

Name: sc_regbank

Overview:
Parametrised general-register bank: NUM_REGS registers of DATAWIDTH_BUS bits, one active-low-committed write/modify port, two combinational read ports.
- Register-local ALU ops: load, increment, decrement, shift, clear.
- Multi-cycle clear-all sequencer with busy indication.
- Registered status flags.
- Sits in the microdatapath as the register file feeding the ALU A/B buses.

Parameters:
DATAWIDTH_BUS, 32, width of every register and data bus (>=2)
NUM_REGS, 8, number of registers (2..2**ADDR_WIDTH)
ADDR_WIDTH, 3, width of address buses

Ports:
SC_RegBANK_CLOCK_50  input  1  system clock, all state updates on rising edge
SC_RegBANK_RESET_InHigh  input  1  synchronous active-high reset
SC_RegBANK_load_InLow  input  1  0 = commit operation this cycle, 1 = hold
SC_RegBANK_op_InBus  input  3  operation code (see Behaviour)
SC_RegBANK_wraddr_InBus  input  ADDR_WIDTH  target register of operation
SC_RegBANK_data_InBus  input  DATAWIDTH_BUS  write data for LOAD
SC_RegBANK_rdaddrA_InBus  input  ADDR_WIDTH  read port A address
SC_RegBANK_rdaddrB_InBus  input  ADDR_WIDTH  read port B address
SC_RegBANK_dataA_OutBus  output  DATAWIDTH_BUS  contents of register rdaddrA
SC_RegBANK_dataB_OutBus  output  DATAWIDTH_BUS  contents of register rdaddrB
SC_RegBANK_busy_Out  output  1  1 while clear-all sequence runs
SC_RegBANK_zero_Out  output  1  last committed result == 0
SC_RegBANK_carry_Out  output  1  carry/borrow/shifted-out bit of last op
SC_RegBANK_negative_Out  output  1  MSB of last committed result

Behaviour:
- One clock; reset synchronous, active-high: on a rising edge with RESET_InHigh=1, all registers=0, FSM=IDLE, clear index=0, busy=0, zero=1, carry=0, negative=0. Reset overrides any op, including mid-clear-all.
- Op codes:
  - 000 LOAD: R = data_InBus
  - 001 INC: R+1
  - 010 DEC: R-1
  - 011 SHL: logical shift left 1, 0 in
  - 100 SHR: logical shift right 1, 0 in
  - 101 CLR: R=0
  - 110 CLRALL: start sequence
  - 111 NOP
- Commit: in IDLE with load_InLow=0, the op applies to R[wraddr] at that rising edge. One-cycle latency: new value is visible on the read ports the following cycle.
- Arithmetic: modulo 2**DATAWIDTH_BUS.
  - Carry: INC = 1 when R was all-ones (wraps to 0). DEC = 1 (borrow) when R was 0 (wraps to all-ones). SHL = old MSB. SHR = old LSB. LOAD/CLR = 0.
- Flags: updated on the same edge as the committed result. zero = (result==0); negative = result[MSB]. Unchanged on NOP, when load_InLow=1, or when wraddr>=NUM_REGS.
- Out-of-range wraddr (>=NUM_REGS): op ignored, no register or flag change; CLRALL still starts.
- Reads: combinational. Address >= NUM_REGS returns 0. A==B is legal.
- FSM:
  - IDLE: CLRALL committed -> CLEARING, index=0, busy=1 from next cycle.
  - CLEARING: each cycle R[index]=0, index++. On the edge clearing index NUM_REGS-1 -> IDLE, busy=0. Total: busy high exactly NUM_REGS cycles.
  - On leaving CLEARING: zero=1, carry=0, negative=0.
- While busy=1, all ops and load_InLow are ignored. Read ports stay live and show partially-cleared contents.

Optional Feature:
SC_REGBANK_BYPASS_EN
- Defined: a read port whose address equals wraddr of a committing single-cycle op (IDLE, load_InLow=0, op in 000..101, wraddr in range) outputs the combinational new result in the same cycle (write-through forwarding).
- Not defined: read ports always show stored contents; the new value appears one cycle later.

Test Plan:
- Reset then LOAD R3=0x0000_00A5 -> next cycle dataA(rdaddrA=3)=0x0000_00A5, zero=0, carry=0, negative=0; R0..R2,R4..R7 read 0.
- LOAD R1=0xFFFF_FFFF, then INC R1 -> R1=0, zero=1, carry=1; then DEC R1 -> R1=0xFFFF_FFFF, carry=1, negative=1.
- LOAD R2=0x8000_0001, SHL -> R2=0x0000_0002, carry=1; SHR -> R2=0x0000_0001, carry=0.
- Load R0..R7 with 1..8, issue CLRALL -> busy=1 for exactly 8 cycles; ops with load_InLow=0 during busy have no effect; afterwards all read 0, zero=1.
- Assert RESET_InHigh at clear index 3 -> next cycle busy=0, all registers 0; LOAD with load_InLow=1 leaves target unchanged; wraddr=9 with ADDR_WIDTH=4, NUM_REGS=8 -> no change, flags unchanged.
- With SC_REGBANK_BYPASS_EN: LOAD R5=0x1234 with rdaddrB=5 -> dataB=0x1234 in the same cycle. Without the macro -> dataB shows the old value that cycle and 0x1234 the next.

Source files
------------

// File: rtl/sc_regbank_if.sv
// Bus bundle for the general-register bank: commit/op/write controls, the two
// read ports and the status flags. The master side drives ops, the slave is the bank.
interface sc_regbank_if #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int ADDR_WIDTH    = 3
);
  logic                     SC_RegBANK_load_InLow;
  logic [2:0]               SC_RegBANK_op_InBus;
  logic [ADDR_WIDTH-1:0]    SC_RegBANK_wraddr_InBus;
  logic [DATAWIDTH_BUS-1:0] SC_RegBANK_data_InBus;
  logic [ADDR_WIDTH-1:0]    SC_RegBANK_rdaddrA_InBus;
  logic [ADDR_WIDTH-1:0]    SC_RegBANK_rdaddrB_InBus;
  logic [DATAWIDTH_BUS-1:0] SC_RegBANK_dataA_OutBus;
  logic [DATAWIDTH_BUS-1:0] SC_RegBANK_dataB_OutBus;
  logic                     SC_RegBANK_busy_Out;
  logic                     SC_RegBANK_zero_Out;
  logic                     SC_RegBANK_carry_Out;
  logic                     SC_RegBANK_negative_Out;

  modport master (
    output SC_RegBANK_load_InLow, SC_RegBANK_op_InBus, SC_RegBANK_wraddr_InBus,
           SC_RegBANK_data_InBus, SC_RegBANK_rdaddrA_InBus, SC_RegBANK_rdaddrB_InBus,
    input  SC_RegBANK_dataA_OutBus, SC_RegBANK_dataB_OutBus, SC_RegBANK_busy_Out,
           SC_RegBANK_zero_Out, SC_RegBANK_carry_Out, SC_RegBANK_negative_Out
  );

  modport slave (
    input  SC_RegBANK_load_InLow, SC_RegBANK_op_InBus, SC_RegBANK_wraddr_InBus,
           SC_RegBANK_data_InBus, SC_RegBANK_rdaddrA_InBus, SC_RegBANK_rdaddrB_InBus,
    output SC_RegBANK_dataA_OutBus, SC_RegBANK_dataB_OutBus, SC_RegBANK_busy_Out,
           SC_RegBANK_zero_Out, SC_RegBANK_carry_Out, SC_RegBANK_negative_Out
  );
endinterface

// File: rtl/sc_regbank.sv
// General-register bank: NUM_REGS registers with a local ALU write port, a
// multi-cycle clear-all sequencer and registered flags. Optional macro
// SC_REGBANK_BYPASS_EN forwards the committing result onto matching read ports.
module sc_regbank #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int NUM_REGS      = 8,
  parameter int ADDR_WIDTH    = 3
) (
  input  logic        SC_RegBANK_CLOCK_50,
  input  logic        SC_RegBANK_RESET_InHigh,
  sc_regbank_if.slave regBus
);

  localparam logic [2:0] OP_LOAD   = 3'b000;
  localparam logic [2:0] OP_INC    = 3'b001;
  localparam logic [2:0] OP_DEC    = 3'b010;
  localparam logic [2:0] OP_SHL    = 3'b011;
  localparam logic [2:0] OP_SHR    = 3'b100;
  localparam logic [2:0] OP_CLR    = 3'b101;
  localparam logic [2:0] OP_CLRALL = 3'b110;

  localparam logic [ADDR_WIDTH:0]   NumRegsW = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] LastIdx  = ADDR_WIDTH'(NUM_REGS-1);

  typedef enum logic {ST_IDLE, ST_CLEARING} state_t;

  state_t                            state_reg, state_next;
  logic [ADDR_WIDTH-1:0]             clearIndex_reg;
  logic [NUM_REGS-1:0][DATAWIDTH_BUS-1:0] regView;
  logic [DATAWIDTH_BUS-1:0]          oldVal, aluResult;
  logic                              aluCarry;
  logic                              inRange, writeEn, startClear, clearing, clearDone;
  logic                              zero_reg, carry_reg, negative_reg;

  wire clk  = SC_RegBANK_CLOCK_50;
  wire srst = SC_RegBANK_RESET_InHigh;

  // Commit qualification: only IDLE accepts ops; out-of-range targets still start CLRALL.
  assign inRange    = ({1'b0, regBus.SC_RegBANK_wraddr_InBus} < NumRegsW);
  assign writeEn    = (state_reg == ST_IDLE) && !regBus.SC_RegBANK_load_InLow &&
                      (regBus.SC_RegBANK_op_InBus <= OP_CLR) && inRange;
  assign startClear = (state_reg == ST_IDLE) && !regBus.SC_RegBANK_load_InLow &&
                      (regBus.SC_RegBANK_op_InBus == OP_CLRALL);
  assign clearDone  = clearing && (clearIndex_reg == LastIdx);

  function automatic logic [DATAWIDTH_BUS-1:0] selectReg(
    input logic [ADDR_WIDTH-1:0]                 addr,
    input logic [NUM_REGS-1:0][DATAWIDTH_BUS-1:0] view
  );
    logic [DATAWIDTH_BUS-1:0] value;
    value = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_WIDTH'(i)) value = view[i];
    end
    return value;
  endfunction

  always_comb begin
    oldVal = selectReg(regBus.SC_RegBANK_wraddr_InBus, regView);
  end

  always_comb begin
    aluResult = oldVal;
    aluCarry  = 1'b0;
    case (regBus.SC_RegBANK_op_InBus)
      OP_LOAD: aluResult = regBus.SC_RegBANK_data_InBus;
      OP_INC:  {aluCarry, aluResult} = {1'b0, oldVal} + (DATAWIDTH_BUS+1)'(1);
      OP_DEC: begin
        aluResult = oldVal - DATAWIDTH_BUS'(1);
        aluCarry  = (oldVal == '0);
      end
      OP_SHL:  {aluCarry, aluResult} = {oldVal, 1'b0};
      OP_SHR:  {aluResult, aluCarry} = {1'b0, oldVal};
      OP_CLR:  aluResult = '0;
      default: aluResult = oldVal;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : gen_reg
      localparam logic [ADDR_WIDTH-1:0] Idx = ADDR_WIDTH'(gi);
      logic [DATAWIDTH_BUS-1:0] value_reg;

      always_ff @(posedge clk) begin
        if (srst) begin
          value_reg <= '0;
        end else if (clearing && (clearIndex_reg == Idx)) begin
          value_reg <= '0;
        end else if (writeEn && (regBus.SC_RegBANK_wraddr_InBus == Idx)) begin
          value_reg <= aluResult;
        end
      end

      assign regView[gi] = value_reg;
    end
  endgenerate

  // FSM: state register
  always_ff @(posedge clk) begin
    if (srst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (startClear) state_next = ST_CLEARING;
      ST_CLEARING: if (clearIndex_reg == LastIdx) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    clearing                   = (state_reg == ST_CLEARING);
    regBus.SC_RegBANK_busy_Out = (state_reg == ST_CLEARING);
  end

  always_ff @(posedge clk) begin
    if (srst || !clearing || clearDone) clearIndex_reg <= '0;
    else                                 clearIndex_reg <= clearIndex_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (srst || clearDone) begin
      zero_reg     <= 1'b1;
      carry_reg    <= 1'b0;
      negative_reg <= 1'b0;
    end else if (writeEn) begin
      zero_reg     <= (aluResult == '0);
      carry_reg    <= aluCarry;
      negative_reg <= aluResult[DATAWIDTH_BUS-1];
    end
  end

  assign regBus.SC_RegBANK_zero_Out     = zero_reg;
  assign regBus.SC_RegBANK_carry_Out    = carry_reg;
  assign regBus.SC_RegBANK_negative_Out = negative_reg;

`ifdef SC_REGBANK_BYPASS_EN
  // Write-through: a read of the register being committed sees the new value now.
  assign regBus.SC_RegBANK_dataA_OutBus =
    (writeEn && (regBus.SC_RegBANK_rdaddrA_InBus == regBus.SC_RegBANK_wraddr_InBus))
      ? aluResult : selectReg(regBus.SC_RegBANK_rdaddrA_InBus, regView);
  assign regBus.SC_RegBANK_dataB_OutBus =
    (writeEn && (regBus.SC_RegBANK_rdaddrB_InBus == regBus.SC_RegBANK_wraddr_InBus))
      ? aluResult : selectReg(regBus.SC_RegBANK_rdaddrB_InBus, regView);
`else
  assign regBus.SC_RegBANK_dataA_OutBus = selectReg(regBus.SC_RegBANK_rdaddrA_InBus, regView);
  assign regBus.SC_RegBANK_dataB_OutBus = selectReg(regBus.SC_RegBANK_rdaddrB_InBus, regView);
`endif

endmodule

// File: tb/tb_sc_regbank.sv
// Directed bench for sc_regbank: ALU ops, flags, clear-all sequencing,
// reset during clear, hold/out-of-range writes and read forwarding.
`timescale 1ns/1ps
module tb_sc_regbank;

  localparam int DW = 32;
  localparam int NR = 8;
  localparam int AW = 4;

  logic clk  = 1'b0;
  logic srst = 1'b1;
  int   nAssert = 0;
  int   nFail   = 0;

  always #5 clk = ~clk;

  sc_regbank_if #(.DATAWIDTH_BUS(DW), .ADDR_WIDTH(AW)) bus ();

  sc_regbank #(.DATAWIDTH_BUS(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
    .SC_RegBANK_CLOCK_50     (clk),
    .SC_RegBANK_RESET_InHigh (srst),
    .regBus                  (bus.slave)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic chkFlags(input string tag, input logic z, input logic c, input logic n);
    chk({tag, ".zero"},  DW'(bus.SC_RegBANK_zero_Out),     DW'(z));
    chk({tag, ".carry"}, DW'(bus.SC_RegBANK_carry_Out),    DW'(c));
    chk({tag, ".neg"},   DW'(bus.SC_RegBANK_negative_Out), DW'(n));
  endtask

  task automatic doOp(input logic [2:0] op, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data, input logic loadN);
    @(negedge clk);
    bus.SC_RegBANK_load_InLow   = loadN;
    bus.SC_RegBANK_op_InBus     = op;
    bus.SC_RegBANK_wraddr_InBus = addr;
    bus.SC_RegBANK_data_InBus   = data;
    @(posedge clk);
    #1;
    bus.SC_RegBANK_load_InLow = 1'b1;
    bus.SC_RegBANK_op_InBus   = 3'b111;
    $display("op=%b addr=%0d data=%h loadN=%b -> busy=%b z=%b c=%b n=%b", op, addr, data, loadN,
             bus.SC_RegBANK_busy_Out, bus.SC_RegBANK_zero_Out,
             bus.SC_RegBANK_carry_Out, bus.SC_RegBANK_negative_Out);
  endtask

  task automatic readChk(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    bus.SC_RegBANK_rdaddrB_InBus = addr;
    #1;
    chk(tag, bus.SC_RegBANK_dataB_OutBus, exp);
  endtask

  initial begin
    int cnt;
    bus.SC_RegBANK_load_InLow    = 1'b1;
    bus.SC_RegBANK_op_InBus      = 3'b111;
    bus.SC_RegBANK_wraddr_InBus  = '0;
    bus.SC_RegBANK_data_InBus    = '0;
    bus.SC_RegBANK_rdaddrA_InBus = '0;
    bus.SC_RegBANK_rdaddrB_InBus = '0;
    repeat (2) @(posedge clk);
    #1;
    srst = 1'b0;

    // Reset state
    chk("rst.busy", DW'(bus.SC_RegBANK_busy_Out), '0);
    chk("rst.dataA", bus.SC_RegBANK_dataA_OutBus, '0);
    chkFlags("rst", 1'b1, 1'b0, 1'b0);

    // LOAD R3
    bus.SC_RegBANK_rdaddrA_InBus = 4'd3;
    doOp(3'b000, 4'd3, 32'h0000_00A5, 1'b0);
    chk("load.r3", bus.SC_RegBANK_dataA_OutBus, 32'h0000_00A5);
    chkFlags("load", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NR; i++) begin
      if (i != 3) readChk($sformatf("load.other%0d", i), AW'(i), '0);
    end

    // INC / DEC wrap with carry and borrow
    bus.SC_RegBANK_rdaddrA_InBus = 4'd1;
    doOp(3'b000, 4'd1, 32'hFFFF_FFFF, 1'b0);
    chkFlags("loadff", 1'b0, 1'b0, 1'b1);
    doOp(3'b001, 4'd1, '0, 1'b0);
    chk("inc.r1", bus.SC_RegBANK_dataA_OutBus, 32'h0);
    chkFlags("inc", 1'b1, 1'b1, 1'b0);
    doOp(3'b010, 4'd1, '0, 1'b0);
    chk("dec.r1", bus.SC_RegBANK_dataA_OutBus, 32'hFFFF_FFFF);
    chkFlags("dec", 1'b0, 1'b1, 1'b1);

    // Shifts
    bus.SC_RegBANK_rdaddrA_InBus = 4'd2;
    doOp(3'b000, 4'd2, 32'h8000_0001, 1'b0);
    doOp(3'b011, 4'd2, '0, 1'b0);
    chk("shl.r2", bus.SC_RegBANK_dataA_OutBus, 32'h0000_0002);
    chkFlags("shl", 1'b0, 1'b1, 1'b0);
    doOp(3'b100, 4'd2, '0, 1'b0);
    chk("shr.r2", bus.SC_RegBANK_dataA_OutBus, 32'h0000_0001);
    chkFlags("shr", 1'b0, 1'b0, 1'b0);

    // CLR single register
    doOp(3'b101, 4'd2, 32'h1234_5678, 1'b0);
    chk("clr.r2", bus.SC_RegBANK_dataA_OutBus, 32'h0);
    chkFlags("clr", 1'b1, 1'b0, 1'b0);

    // Fill, then CLRALL with ops attempted while busy
    for (int i = 0; i < NR; i++) doOp(3'b000, AW'(i), DW'(i + 1), 1'b0);
    doOp(3'b000, 4'd6, 32'hC000_0000, 1'b0);
    doOp(3'b011, 4'd6, '0, 1'b0);
    chkFlags("preclr", 1'b0, 1'b1, 1'b1);
    bus.SC_RegBANK_rdaddrA_InBus = 4'd0;
    doOp(3'b110, 4'd0, '0, 1'b0);
    chk("clrall.firstR0", bus.SC_RegBANK_dataA_OutBus, 32'd1);
    bus.SC_RegBANK_load_InLow   = 1'b0;
    bus.SC_RegBANK_op_InBus     = 3'b000;
    bus.SC_RegBANK_wraddr_InBus = 4'd5;
    bus.SC_RegBANK_data_InBus   = 32'hDEAD_BEEF;
    cnt = 0;
    while (bus.SC_RegBANK_busy_Out && cnt < 20) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    bus.SC_RegBANK_load_InLow = 1'b1;
    bus.SC_RegBANK_op_InBus   = 3'b111;
    $display("clrall busy cycles=%0d", cnt);
    chk("clrall.busyCycles", DW'(cnt), DW'(NR));
    chkFlags("clrall", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < NR; i++) readChk($sformatf("clrall.r%0d", i), AW'(i), '0);

    // Reset in the middle of a clear-all
    doOp(3'b000, 4'd4, 32'h44, 1'b0);
    doOp(3'b000, 4'd7, 32'h77, 1'b0);
    doOp(3'b110, 4'd0, '0, 1'b0);
    chk("midclr.busy", DW'(bus.SC_RegBANK_busy_Out), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    srst = 1'b1;
    @(posedge clk);
    #1;
    srst = 1'b0;
    chk("midrst.busy", DW'(bus.SC_RegBANK_busy_Out), '0);
    readChk("midrst.r4", 4'd4, '0);
    readChk("midrst.r7", 4'd7, '0);
    chkFlags("midrst", 1'b1, 1'b0, 1'b0);

    // Hold (load_InLow=1) leaves target unchanged
    doOp(3'b000, 4'd2, 32'h55, 1'b1);
    readChk("hold.r2", 4'd2, '0);
    chkFlags("hold", 1'b1, 1'b0, 1'b0);

    // Out-of-range target: no register or flag change, read returns 0
    doOp(3'b000, 4'd2, 32'h8000_0000, 1'b0);
    doOp(3'b000, 4'd9, 32'h0, 1'b0);
    chkFlags("oor", 1'b0, 1'b0, 1'b1);
    readChk("oor.r2", 4'd2, 32'h8000_0000);
    readChk("oor.read9", 4'd9, '0);

    // CLRALL with out-of-range target still starts
    doOp(3'b110, 4'd9, '0, 1'b0);
    chk("oorclr.busy", DW'(bus.SC_RegBANK_busy_Out), 32'd1);
    cnt = 0;
    while (bus.SC_RegBANK_busy_Out && cnt < 20) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    chk("oorclr.busyCycles", DW'(cnt), DW'(NR));
    readChk("oorclr.r2", 4'd2, '0);

    // Forwarding on read port B
    bus.SC_RegBANK_rdaddrB_InBus = 4'd5;
    @(negedge clk);
    bus.SC_RegBANK_load_InLow   = 1'b0;
    bus.SC_RegBANK_op_InBus     = 3'b000;
    bus.SC_RegBANK_wraddr_InBus = 4'd5;
    bus.SC_RegBANK_data_InBus   = 32'h1234;
    #1;
`ifdef SC_REGBANK_BYPASS_EN
    chk("bypass.same", bus.SC_RegBANK_dataB_OutBus, 32'h1234);
`else
    chk("bypass.same", bus.SC_RegBANK_dataB_OutBus, 32'h0);
`endif
    @(posedge clk);
    #1;
    bus.SC_RegBANK_load_InLow = 1'b1;
    bus.SC_RegBANK_op_InBus   = 3'b111;
    chk("bypass.next", bus.SC_RegBANK_dataB_OutBus, 32'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
